// File: rtl/frame_src_arbiter.sv
// frame_src_arbiter
//   Shares one video pipeline between two sources at frame granularity.
//   A source is granted round-robin. Its stream is forwarded from its next
//   vsync rising edge to its vsync falling edge, with one register stage.
//   Each frame is tagged with its source ID, and its geometry is checked
//   at end of frame.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   src_en[1:0]                   per-source enable
//   s0_* / s1_*                   source vsync/hsync/valid/data
//   post_img_*                    forwarded stream (0 outside forwarded cycles)
//   post_src_id                   source of the frame being forwarded
//   frame_done                    1-cycle pulse, aligned with post_img_vsync falling
//   frame_err                     pulse with frame_done when pixel/line count is wrong

module frame_src_arbiter #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        src_en,
  input  logic              s0_vsync,
  input  logic              s0_hsync,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_vsync,
  input  logic              s1_hsync,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  output logic              post_img_vsync,
  output logic              post_img_hsync,
  output logic              post_img_valid,
  output logic [DATA_W-1:0] post_img_data,
  output logic              post_src_id,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned PIX_W  = $clog2(IMG_W * IMG_H + 1);
  localparam int unsigned LINE_W = $clog2(IMG_H + 1);
  localparam logic [PIX_W-1:0]  PIX_TGT  = PIX_W'(IMG_W * IMG_H);
  localparam logic [LINE_W-1:0] LINE_TGT = LINE_W'(IMG_H);

  typedef enum logic [1:0] {IDLE, SELECT, WAIT_SOF, PASS} state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   vs_prev_q, vs_prev_d;
  logic   vld_prev_q, vld_prev_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0] line_cnt_q, line_cnt_d;

  logic              out_vsync_q, out_vsync_d;
  logic              out_hsync_q, out_hsync_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              src_id_q, src_id_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              g_vsync, g_hsync, g_valid;
  logic [DATA_W-1:0] g_data;
  logic              sel;
  logic              fwd;
  logic              sof, eof, line_end;
  logic [PIX_W-1:0]  pix_inc;
  logic [LINE_W-1:0] line_inc;

  // Granted source view; the other source is never looked at.
  always_comb begin
    g_vsync = grant_q ? s1_vsync : s0_vsync;
    g_hsync = grant_q ? s1_hsync : s0_hsync;
    g_valid = grant_q ? s1_valid : s0_valid;
    g_data  = grant_q ? s1_data  : s0_data;
  end

  always_comb begin
    sof      = g_vsync & ~vs_prev_q;
    eof      = ~g_vsync & vs_prev_q;
    line_end = ~g_valid & vld_prev_q;

    pix_inc = pix_cnt_q;
    if (g_valid && pix_cnt_q != '1) pix_inc = pix_cnt_q + PIX_W'(1);
    line_inc = line_cnt_q;
    if (line_end && line_cnt_q != '1) line_inc = line_cnt_q + LINE_W'(1);

    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    src_id_d     = src_id_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    fwd          = 1'b0;
    sel          = grant_q;

    case (state_q)
      IDLE: begin
        if (src_en != 2'b00) state_d = SELECT;
      end
      SELECT: begin
        if (src_en == 2'b00) begin
          state_d = IDLE;
        end else begin
          grant_d = src_en[~last_grant_q] ? ~last_grant_q : last_grant_q;
          state_d = WAIT_SOF;
        end
        sel = grant_d;
      end
      WAIT_SOF: begin
        if (!src_en[grant_q]) begin
          state_d = SELECT;
        end else if (sof) begin
          fwd        = 1'b1;
          src_id_d   = grant_q;
          pix_cnt_d  = g_valid ? PIX_W'(1) : '0;
          line_cnt_d = '0;
          state_d    = PASS;
        end
      end
      PASS: begin
        fwd        = 1'b1;
        pix_cnt_d  = pix_inc;
        line_cnt_d = line_inc;
        if (eof) begin
          // line_inc already counts a last line whose valid drops together with vsync.
          done_d       = 1'b1;
          err_d        = (pix_inc != PIX_TGT) || (line_inc != LINE_TGT);
          last_grant_d = grant_q;
          pix_cnt_d    = '0;
          line_cnt_d   = '0;
          state_d      = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Edge history follows the source that will be granted next cycle, so a
    // freshly granted source already in mid-frame is not mistaken for a rising edge.
    vs_prev_d  = sel ? s1_vsync : s0_vsync;
    vld_prev_d = sel ? s1_valid : s0_valid;

    out_vsync_d = fwd ? g_vsync : 1'b0;
    out_hsync_d = fwd ? g_hsync : 1'b0;
    out_valid_d = fwd ? g_valid : 1'b0;
    out_data_d  = fwd ? g_data  : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      vs_prev_q    <= 1'b0;
      vld_prev_q   <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      out_vsync_q  <= 1'b0;
      out_hsync_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      src_id_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      vs_prev_q    <= vs_prev_d;
      vld_prev_q   <= vld_prev_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      out_vsync_q  <= out_vsync_d;
      out_hsync_q  <= out_hsync_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      src_id_q     <= src_id_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign post_img_vsync = out_vsync_q;
  assign post_img_hsync = out_hsync_q;
  assign post_img_valid = out_valid_q;
  assign post_img_data  = out_data_q;
  assign post_src_id    = src_id_q;
  assign frame_done     = done_q;
  assign frame_err      = err_q;

endmodule

// File: tb/tb_frame_src_arbiter.sv
// Directed bench for frame_src_arbiter using a reduced 4x3 frame geometry.
// Every cycle the forwarded bus, source tag and done/err flags are compared
// against values rebuilt from the stimulus just applied.
module tb_frame_src_arbiter;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    src_en;
  logic          s0_vsync, s0_hsync, s0_valid;
  logic [DW-1:0] s0_data;
  logic          s1_vsync, s1_hsync, s1_valid;
  logic [DW-1:0] s1_data;
  logic          post_img_vsync, post_img_hsync, post_img_valid;
  logic [DW-1:0] post_img_data;
  logic          post_src_id, frame_done, frame_err;

  int            tests = 0;
  int            fails = 0;
  int            done_seen = 0;
  int            err_seen = 0;
  logic          exp_id = 1'b0;
  logic [7:0]    dcnt = 8'h00;

  always #5 clk = ~clk;

  frame_src_arbiter #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .src_en(src_en),
    .s0_vsync(s0_vsync), .s0_hsync(s0_hsync), .s0_valid(s0_valid), .s0_data(s0_data),
    .s1_vsync(s1_vsync), .s1_hsync(s1_hsync), .s1_valid(s1_valid), .s1_data(s1_data),
    .post_img_vsync(post_img_vsync), .post_img_hsync(post_img_hsync),
    .post_img_valid(post_img_valid), .post_img_data(post_img_data),
    .post_src_id(post_src_id), .frame_done(frame_done), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_bus();
    return {18'd0, post_img_vsync, post_img_hsync, post_img_valid, post_img_data,
            post_src_id, frame_done, frame_err};
  endfunction

  // Apply one cycle of stimulus, clock it, then check the registered outputs.
  task automatic cycle(input logic drv0, input logic drv1, input logic vs, input logic hs,
                       input logic v, input logic fwd, input logic gsrc,
                       input logic edone, input logic eerr, input string tag);
    logic [7:0]  d0, d1;
    logic [10:0] eb;
    d0 = drv0 ? dcnt : 8'h00;
    d1 = drv1 ? ~dcnt : 8'h00;
    s0_vsync = drv0 & vs; s0_hsync = drv0 & hs; s0_valid = drv0 & v; s0_data = d0;
    s1_vsync = drv1 & vs; s1_hsync = drv1 & hs; s1_valid = drv1 & v; s1_data = d1;
    @(posedge clk); #1;
    dcnt++;
    eb = fwd ? (gsrc ? {vs, hs, v, d1} : {vs, hs, v, d0}) : 11'd0;
    chk(tag, out_bus(), {18'd0, eb, exp_id, edone, eerr});
    if (frame_done) done_seen++;
    if (frame_err) err_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  // One frame: rise cycle, `lines` lines (hsync lead-in, pixels, blank),
  // then the vsync falling cycle. merge drops the last blank so the final
  // line's valid falls together with vsync.
  task automatic frame(input string tag, input logic [1:0] drv, input logic fwd,
                       input logic gsrc, input int lines, input int extra, input bit merge,
                       input logic eerr, input int en_at, input logic [1:0] en_val,
                       input int rst_at);
    logic [2:0] seq[$];
    logic       fw;
    logic       last;
    fw = fwd;
    if (fw) exp_id = gsrc;
    seq.push_back(3'b100);
    for (int l = 0; l < lines; l++) begin
      seq.push_back(3'b110);
      for (int p = 0; p < W + ((l == 0) ? extra : 0); p++) seq.push_back(3'b111);
      if (!(merge && l == lines - 1)) seq.push_back(3'b100);
    end
    seq.push_back(3'b000);
    foreach (seq[i]) begin
      last = (i == seq.size() - 1);
      if (i == en_at) src_en = en_val;
      cycle(drv[0], drv[1], seq[i][2], seq[i][1], seq[i][0], fw, gsrc,
            fw && last, fw && last && eerr, tag);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk({tag, " async_rst"}, out_bus(), 32'd0);
        #1;
        rst = 1'b0;
        fw = 1'b0;
        exp_id = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    src_en = 2'b00;
    s0_vsync = 0; s0_hsync = 0; s0_valid = 0; s0_data = '0;
    s1_vsync = 0; s1_hsync = 0; s1_valid = 0; s1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", out_bus(), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single source, three frames with the minimum 2-cycle vsync-low gap.
    src_en = 2'b01;
    idle(3);
    repeat (3) begin
      frame("single", 2'b01, 1, 0, H, 0, 0, 0, -1, 2'b00, -1);
      idle(1);
    end
    chk("single_done_count", done_seen, 3);

    // Both sources streaming in lockstep: s0, s1, s0, s1.
    src_en = 2'b11;
    frame("alt0_s0", 2'b11, 1, 0, H, 0, 0, 0, -1, 2'b00, -1); idle(1);
    frame("alt1_s1", 2'b11, 1, 1, H, 0, 0, 0, -1, 2'b00, -1); idle(1);
    frame("alt2_s0", 2'b11, 1, 0, H, 0, 0, 0, -1, 2'b00, -1); idle(1);
    frame("alt3_s1", 2'b11, 1, 1, H, 0, 0, 0, -1, 2'b00, -1);
    chk("alt_done_count", done_seen, 7);

    // Enable arrives while s0 is mid-frame: that frame is skipped.
    src_en = 2'b00;
    idle(2);
    frame("midgrant_skip", 2'b01, 0, 0, H, 0, 0, 0, 5, 2'b01, -1); idle(1);
    frame("midgrant_full", 2'b01, 1, 0, H, 0, 0, 0, -1, 2'b00, -1); idle(1);

    // Disable halfway through a forwarded frame: it still completes.
    frame("disable_pass", 2'b01, 1, 0, H, 0, 0, 0, 10, 2'b00, -1); idle(1);
    frame("disabled_out", 2'b01, 0, 0, H, 0, 0, 0, -1, 2'b00, -1); idle(2);

    // Geometry: short frame, extra pixel, merged final line, good frame.
    src_en = 2'b01;
    idle(3);
    frame("short_frame", 2'b01, 1, 0, H - 1, 0, 0, 1, -1, 2'b00, -1); idle(1);
    frame("extra_pixel", 2'b01, 1, 0, H, 1, 0, 1, -1, 2'b00, -1); idle(1);
    frame("merge_tail", 2'b01, 1, 0, H, 0, 1, 0, -1, 2'b00, -1); idle(1);
    frame("good_after_err", 2'b01, 1, 0, H, 0, 0, 0, -1, 2'b00, -1);
    chk("err_count_geom", err_seen, 2);

    // Async reset in the middle of an s1 frame; s0 wins first afterwards.
    src_en = 2'b11;
    idle(1);
    frame("rst_mid_s1", 2'b11, 1, 1, H, 0, 0, 0, -1, 2'b00, 8); idle(1);
    frame("post_rst_s0", 2'b11, 1, 0, H, 0, 0, 0, -1, 2'b00, -1);
    idle(2);

    chk("done_total", done_seen, 14);
    chk("err_total", err_seen, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
